// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
package mem_arb_pkg;

    // Upper bound on requester count; helpers work at this width and callers cast down.
    localparam int MAXN = 16;

    typedef enum logic {
        IDLE,
        OWNED
    } arb_state_e;

    // Binary index of the set bit in a one-hot vector (0 when none is set).
    function automatic int unsigned onehot_to_idx(input logic [MAXN-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAXN; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

    // Ones strictly above idx; the caller truncates to N bits, so idx = N-1 yields zero.
    function automatic logic [MAXN-1:0] mask_above(input int unsigned idx);
        logic [MAXN-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAXN; i++) begin
            m[i] = (i > idx);
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// PriorityArbiter: fixed-priority one-hot pick, lowest index wins.
module PriorityArbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    // Isolate the lowest set bit of the request vector.
    always_comb begin
        grant = req & (~req + N'(1));
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter with burst lock for one memory port.
// Optional stall-timeout release is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int IDXW    = $clog2(N),
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    req_last,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_valid,
    input  logic            mem_ready,
    output logic [N-1:0]    accept,
    output logic            timeout_err
);

    arb_state_e      state;
    logic [N-1:0]    mask;
    logic [N-1:0]    masked_req;
    logic [N-1:0]    pick_masked;
    logic [N-1:0]    pick_unmasked;
    logic [N-1:0]    pick;
    logic [IDXW-1:0] pick_idx;
    logic [N-1:0]    mask_rel;
    logic            xfer;
    logic            own_last;
    logic            stall_expire;
    logic            done;

    assign masked_req = req & mask;

    PriorityArbiter #(.N(N)) u_prio_masked (
        .req   (masked_req),
        .grant (pick_masked)
    );

    PriorityArbiter #(.N(N)) u_prio_unmasked (
        .req   (req),
        .grant (pick_unmasked)
    );

    // Round-robin pick: masked requests first, fall back to plain fixed priority.
    always_comb begin
        pick     = (|masked_req) ? pick_masked : pick_unmasked;
        pick_idx = IDXW'(onehot_to_idx(MAXN'(pick)));
    end

    // Beat qualification and burst-end detection for the current owner.
    always_comb begin
        accept      = grant & {N{mem_ready}};
        grant_valid = |grant;
        xfer        = grant_valid & mem_ready & (|(req & grant));
        own_last    = |(req_last & grant);
        mask_rel    = N'(mask_above(32'(grant_idx)));
        done        = (xfer & own_last) | stall_expire;
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);

    logic [CNTW-1:0] stall_cnt;

    // Stall counter is held at zero outside OWNED, so it enters OWNED cleared.
    always_ff @(posedge clk) begin
        if (reset || state != OWNED || xfer) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + CNTW'(1);
        end
    end

    // Release when this stalled cycle brings the count to TIMEOUT.
    always_comb begin
        stall_expire = (state == OWNED) && !xfer && (stall_cnt == CNTW'(TIMEOUT - 1));
    end
`else
    // Without the timeout feature a stalled burst is held indefinitely.
    always_comb begin
        stall_expire = 1'b0;
    end
`endif

    // Arbitration FSM with registered grant, index, mask and timeout pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            mask        <= '1;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        grant     <= pick;
                        grant_idx <= pick_idx;
                        state     <= OWNED;
                    end
                end
                OWNED: begin
                    if (done) begin
                        grant       <= '0;
                        grant_idx   <= '0;
                        mask        <= mask_rel;
                        state       <= IDLE;
                        timeout_err <= stall_expire;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter (N=4); define MEM_ARB_TIMEOUT_EN to cover the timeout path.
module tb_mem_port_arbiter;

    localparam int N = 4;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] req_last = '0;
    logic       mem_ready = 1'b0;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic [3:0] accept;
    logic       timeout_err;

    mem_port_arbiter #(
        .N       (N),
        .IDXW    (2),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_last    (req_last),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .mem_ready   (mem_ready),
        .accept      (accept),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // One cycle: inputs held during the cycle, accept seen during it, grant/tmo after the edge.
    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] last;
        logic       rdy;
        logic [3:0] acc;
        logic [3:0] gnt;
        logic       tmo;
    } vec_t;

    typedef struct {
        logic [3:0] acc;
        logic [3:0] gnt;
        logic       tmo;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   row   = 0;

    function automatic void add(input logic rst, input logic [3:0] rq, input logic [3:0] lst,
                                input logic rdy, input logic [3:0] acc, input logic [3:0] gnt,
                                input logic tmo);
        vec_t v;
        v.rst = rst; v.req = rq; v.last = lst; v.rdy = rdy;
        v.acc = acc; v.gnt = gnt; v.tmo = tmo;
        tbl.push_back(v);
    endfunction

    function automatic logic [1:0] idx_of(input logic [3:0] oh);
        case (oh)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic chk(input string name, input int r, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %0h required %0h", name, r, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        @(negedge clk);
        reset     = v.rst;
        req       = v.req;
        req_last  = v.last;
        mem_ready = v.rdy;
        e.acc = v.acc; e.gnt = v.gnt; e.tmo = v.tmo;
        sb.push_back(e);
        #1;
        chk("accept", row, 16'(accept), 16'(sb[0].acc));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("grant", row, 16'(grant), 16'(e.gnt));
        chk("grant_idx", row, 16'(grant_idx), 16'(idx_of(e.gnt)));
        chk("grant_valid", row, 16'(grant_valid), 16'(e.gnt != 4'b0000));
        chk("timeout_err", row, 16'(timeout_err), 16'(e.tmo));
        row++;
    endtask

    task automatic hs(input logic rst, input logic [3:0] rq, input logic [3:0] lst, input logic rdy,
                      input logic [3:0] acc, input logic [3:0] gnt, input logic tmo);
        vec_t v;
        v.rst = rst; v.req = rq; v.last = lst; v.rdy = rdy;
        v.acc = acc; v.gnt = gnt; v.tmo = tmo;
        step(v);
    endtask

    initial begin
        // Reset held, then idle with no requests.
        add(1, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0);
        add(1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);
        for (int i = 0; i < 10; i++) begin
            add(0, 4'b0000, 4'b0000, logic'(i % 2), 4'b0000, 4'b0000, 0);
        end
        // Fairness: all requesting single-beat bursts, one grant per two cycles with wrap.
        add(0, 4'b1111, 4'b1111, 1, 4'b0000, 4'b0001, 0);
        add(0, 4'b1111, 4'b1111, 1, 4'b0001, 4'b0000, 0);
        add(0, 4'b1111, 4'b1111, 1, 4'b0000, 4'b0010, 0);
        add(0, 4'b1111, 4'b1111, 1, 4'b0010, 4'b0000, 0);
        add(0, 4'b1111, 4'b1111, 1, 4'b0000, 4'b0100, 0);
        add(0, 4'b1111, 4'b1111, 1, 4'b0100, 4'b0000, 0);
        add(0, 4'b1111, 4'b1111, 1, 4'b0000, 4'b1000, 0);
        add(0, 4'b1111, 4'b1111, 1, 4'b1000, 4'b0000, 0);
        add(0, 4'b1111, 4'b1111, 1, 4'b0000, 4'b0001, 0);
        add(0, 4'b1111, 4'b1111, 1, 4'b0001, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);
        // Three-beat burst on requester 2 with a stall; requester 0 arrives mid-burst.
        add(0, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0100, 0);
        add(0, 4'b0100, 4'b0000, 1, 4'b0100, 4'b0100, 0);
        add(0, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0100, 0);
        add(0, 4'b0101, 4'b0000, 1, 4'b0100, 4'b0100, 0);
        add(0, 4'b0101, 4'b0100, 1, 4'b0100, 4'b0000, 0);
        add(0, 4'b0101, 4'b0000, 0, 4'b0000, 4'b0001, 0);
        add(0, 4'b0101, 4'b0001, 1, 4'b0001, 4'b0000, 0);
        add(0, 4'b0101, 4'b0100, 0, 4'b0000, 4'b0100, 0);
        add(0, 4'b0101, 4'b0100, 1, 4'b0100, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);
        // Release at index 3 empties the mask; next pick falls back to unmasked priority.
        add(0, 4'b1000, 4'b1000, 1, 4'b0000, 4'b1000, 0);
        add(0, 4'b1000, 4'b1000, 1, 4'b1000, 4'b0000, 0);
        add(0, 4'b0101, 4'b0101, 0, 4'b0000, 4'b0001, 0);
        add(0, 4'b0101, 4'b0101, 1, 4'b0001, 4'b0000, 0);
        add(0, 4'b0101, 4'b0101, 0, 4'b0000, 4'b0100, 0);
        add(0, 4'b0101, 4'b0101, 1, 4'b0100, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);

        reset = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Owner drops req mid-burst: grant held, no transfer; others ignored while owned.
        hs(0, 4'b0010, 4'b0000, 0, 4'b0000, 4'b0010, 0);
        hs(0, 4'b0000, 4'b0010, 1, 4'b0010, 4'b0010, 0);
        hs(0, 4'b1001, 4'b0000, 0, 4'b0000, 4'b0010, 0);
        hs(0, 4'b0010, 4'b0010, 1, 4'b0010, 4'b0000, 0);
        hs(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Stalled owner is released on the 8th stall cycle with a single timeout pulse.
        hs(0, 4'b0101, 4'b0000, 0, 4'b0000, 4'b0100, 0);
        for (int i = 0; i < 7; i++) begin
            hs(0, 4'b0101, 4'b0000, 0, 4'b0000, 4'b0100, 0);
        end
        hs(0, 4'b0101, 4'b0000, 0, 4'b0000, 4'b0000, 1);
        hs(0, 4'b0101, 4'b0000, 0, 4'b0000, 4'b0001, 0);
        hs(0, 4'b0101, 4'b0001, 1, 4'b0001, 4'b0000, 0);
        hs(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);
`else
        // Stalled owner is held indefinitely.
        hs(0, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0100, 0);
        for (int i = 0; i < 20; i++) begin
            hs(0, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0100, 0);
        end
        hs(0, 4'b0100, 4'b0100, 1, 4'b0100, 4'b0000, 0);
        hs(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);
`endif

        // Reset during an accepted non-last beat clears grant and restores the full mask.
        hs(0, 4'b0010, 4'b0000, 0, 4'b0000, 4'b0010, 0);
        hs(0, 4'b0010, 4'b0010, 1, 4'b0010, 4'b0000, 0);
        hs(0, 4'b0010, 4'b0000, 0, 4'b0000, 4'b0010, 0);
        hs(1, 4'b0010, 4'b0000, 1, 4'b0010, 4'b0000, 0);
        hs(0, 4'b0110, 4'b0110, 0, 4'b0000, 4'b0010, 0);
        hs(0, 4'b0110, 4'b0110, 1, 4'b0010, 4'b0000, 0);
        hs(0, 4'b0110, 4'b0110, 0, 4'b0000, 4'b0100, 0);
        hs(0, 4'b0110, 4'b0110, 1, 4'b0100, 4'b0000, 0);
        hs(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
